// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter. It shifts one input bit per clock, so done follows
// the accepting edge by BIN_W cycles. A start while busy is dropped, and a start in the done cycle is accepted.
module bin_to_bcd_seq #(
   parameter int BIN_W  = 16,
   parameter int DIGITS = 5,
   parameter int SIGNED = 0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [BIN_W-1:0]      bin,
   output logic                  busy,
   output logic                  done,
   output logic [4*DIGITS-1:0]   bcd,
   output logic                  overflow,
   output logic                  negative
);

   localparam int CW = $clog2(BIN_W + 1);
   localparam int BW = 4 * DIGITS;

   typedef enum logic {IDLE, CONV} state_t;

   state_t           state, state_n;
   logic [CW-1:0]    cnt, cnt_n;
   logic [BIN_W-1:0] sh, sh_n;
   logic [BW-1:0]    work, work_n, adj;
   logic             sticky, sticky_n;
   logic             neg, neg_n;
   logic             done_n;
   logic [BW-1:0]    bcd_n;
   logic             overflow_n, negative_n;

   assign busy = (state == CONV);

   // Add-3 correction applied to every digit before the shift; digits are independent.
   always_comb begin
      adj = work;
      for (int k = 0; k < DIGITS; k++) begin
         if (work[4*k +: 4] >= 4'd5)
            adj[4*k +: 4] = work[4*k +: 4] + 4'd3;
      end
   end

   always_comb begin
      state_n    = state;
      cnt_n      = cnt;
      sh_n       = sh;
      work_n     = work;
      sticky_n   = sticky;
      neg_n      = neg;
      done_n     = 1'b0;
      bcd_n      = bcd;
      overflow_n = overflow;
      negative_n = negative;
      case (state)
         IDLE: begin
            if (start) begin
               if (SIGNED != 0 && bin[BIN_W-1]) begin
                  sh_n  = ~bin + BIN_W'(1);
                  neg_n = 1'b1;
               end else begin
                  sh_n  = bin;
                  neg_n = 1'b0;
               end
               work_n   = '0;
               sticky_n = 1'b0;
               cnt_n    = CW'(BIN_W);
               state_n  = CONV;
            end
         end
         CONV: begin
            // Working BCD and shift register move together as one vector.
            work_n   = {adj[BW-2:0], sh[BIN_W-1]};
            sh_n     = {sh[BIN_W-2:0], 1'b0};
            sticky_n = sticky | adj[BW-1];
            cnt_n    = cnt - CW'(1);
            if (cnt == CW'(1)) begin
               bcd_n      = work_n;
               overflow_n = sticky_n;
               negative_n = neg;
               done_n     = 1'b1;
               state_n    = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         cnt      <= '0;
         sh       <= '0;
         work     <= '0;
         sticky   <= 1'b0;
         neg      <= 1'b0;
         done     <= 1'b0;
         bcd      <= '0;
         overflow <= 1'b0;
         negative <= 1'b0;
      end else begin
         state    <= state_n;
         cnt      <= cnt_n;
         sh       <= sh_n;
         work     <= work_n;
         sticky   <= sticky_n;
         neg      <= neg_n;
         done     <= done_n;
         bcd      <= bcd_n;
         overflow <= overflow_n;
         negative <= negative_n;
      end
   end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed bench for bin_to_bcd_seq, covering four parameter sets that share one clock and reset.
module tb_bin_to_bcd_seq;

   logic        clk;
   logic        rst_n;
   logic        start_v [4];
   logic [31:0] bin_v   [4];
   logic        busy_v  [4];
   logic        done_v  [4];
   logic        ovf_v   [4];
   logic        neg_v   [4];
   logic [39:0] bcd_v   [4];

   logic [19:0] bcd_a;
   logic [15:0] bcd_b;
   logic [19:0] bcd_s;
   logic [39:0] bcd_w;

   int checks = 0;
   int errors = 0;

   // 0: 16b/5 digits unsigned, 1: 16b/4 digits, 2: 16b/5 digits signed, 3: 32b/10 digits
   bin_to_bcd_seq #(.BIN_W(16), .DIGITS(5), .SIGNED(0)) u_a (
      .clk(clk), .rst_n(rst_n), .start(start_v[0]), .bin(bin_v[0][15:0]),
      .busy(busy_v[0]), .done(done_v[0]), .bcd(bcd_a), .overflow(ovf_v[0]), .negative(neg_v[0]));
   bin_to_bcd_seq #(.BIN_W(16), .DIGITS(4), .SIGNED(0)) u_b (
      .clk(clk), .rst_n(rst_n), .start(start_v[1]), .bin(bin_v[1][15:0]),
      .busy(busy_v[1]), .done(done_v[1]), .bcd(bcd_b), .overflow(ovf_v[1]), .negative(neg_v[1]));
   bin_to_bcd_seq #(.BIN_W(16), .DIGITS(5), .SIGNED(1)) u_s (
      .clk(clk), .rst_n(rst_n), .start(start_v[2]), .bin(bin_v[2][15:0]),
      .busy(busy_v[2]), .done(done_v[2]), .bcd(bcd_s), .overflow(ovf_v[2]), .negative(neg_v[2]));
   bin_to_bcd_seq #(.BIN_W(32), .DIGITS(10), .SIGNED(0)) u_w (
      .clk(clk), .rst_n(rst_n), .start(start_v[3]), .bin(bin_v[3]),
      .busy(busy_v[3]), .done(done_v[3]), .bcd(bcd_w), .overflow(ovf_v[3]), .negative(neg_v[3]));

   assign bcd_v[0] = {20'd0, bcd_a};
   assign bcd_v[1] = {24'd0, bcd_b};
   assign bcd_v[2] = {20'd0, bcd_s};
   assign bcd_v[3] = bcd_w;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Runs one conversion on instance i. bin is scrambled after the accepting edge;
   // with poke set, a different start request is issued mid-conversion.
   task automatic run(input int i, input logic [31:0] v, input logic [39:0] eb,
                      input logic eo, input logic en, input int lat, input bit poke,
                      input string tag);
      int n;
      @(negedge clk);
      start_v[i] = 1'b1;
      bin_v[i]   = v;
      @(posedge clk);
      #1;
      start_v[i] = 1'b0;
      bin_v[i]   = ~v;
      chk({tag, "_busy_after_e0"}, {39'd0, busy_v[i]}, 40'd1);
      n = 0;
      do begin
         @(posedge clk);
         #1;
         n++;
         if (poke && n == 5) begin
            start_v[i] = 1'b1;
            bin_v[i]   = 32'd999;
         end
         if (poke && n == 6) start_v[i] = 1'b0;
      end while (done_v[i] !== 1'b1 && n < lat + 10);
      chk({tag, "_latency"}, 40'(n), 40'(lat));
      chk({tag, "_bcd"}, bcd_v[i], eb);
      chk({tag, "_ovf"}, {39'd0, ovf_v[i]}, {39'd0, eo});
      chk({tag, "_neg"}, {39'd0, neg_v[i]}, {39'd0, en});
      chk({tag, "_busy_at_done"}, {39'd0, busy_v[i]}, 40'd0);
      @(posedge clk);
      #1;
      chk({tag, "_done_width"}, {39'd0, done_v[i]}, 40'd0);
      chk({tag, "_idle_after"}, {39'd0, busy_v[i]}, 40'd0);
   endtask

   initial begin
      int n;
      int pulses;
      rst_n = 1'b0;
      for (int i = 0; i < 4; i++) begin
         start_v[i] = 1'b0;
         bin_v[i]   = 32'd0;
      end
      repeat (3) @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) begin
         chk("rst_busy", {39'd0, busy_v[i]}, 40'd0);
         chk("rst_done", {39'd0, done_v[i]}, 40'd0);
         chk("rst_bcd", bcd_v[i], 40'd0);
         chk("rst_ovf", {39'd0, ovf_v[i]}, 40'd0);
         chk("rst_neg", {39'd0, neg_v[i]}, 40'd0);
      end
      @(negedge clk);
      rst_n = 1'b1;

      run(0, 32'd65535, 40'h65535, 1'b0, 1'b0, 16, 1'b0, "a_65535");
      run(0, 32'd0,     40'h00000, 1'b0, 1'b0, 16, 1'b0, "a_zero");
      run(0, 32'd1234,  40'h01234, 1'b0, 1'b0, 16, 1'b1, "a_1234_poke");

      run(1, 32'd9999,  40'h9999, 1'b0, 1'b0, 16, 1'b0, "b_9999");
      run(1, 32'd10000, 40'h0000, 1'b1, 1'b0, 16, 1'b0, "b_10000");
      run(1, 32'd65535, 40'h5535, 1'b1, 1'b0, 16, 1'b0, "b_65535");

      run(2, 32'h8000, 40'h32768, 1'b0, 1'b1, 16, 1'b0, "s_8000");
      run(2, 32'h7FFF, 40'h32767, 1'b0, 1'b0, 16, 1'b0, "s_7fff");
      run(2, 32'hFFFF, 40'h00001, 1'b0, 1'b1, 16, 1'b0, "s_ffff");

      run(3, 32'hFFFFFFFF, 40'h4294967295, 1'b0, 1'b0, 32, 1'b0, "w_max");

      // start held high: back-to-back conversions every 17 cycles
      @(negedge clk);
      start_v[0] = 1'b1;
      bin_v[0]   = 32'd7;
      n = 0;
      do begin
         @(posedge clk);
         #1;
         n++;
      end while (done_v[0] !== 1'b1 && n < 40);
      chk("bb_first_latency", 40'(n), 40'd17);
      chk("bb_first_bcd", bcd_v[0], 40'h00007);
      for (int p = 0; p < 3; p++) begin
         n = 0;
         do begin
            @(posedge clk);
            #1;
            n++;
            if (n == 1) chk("bb_done_width", {39'd0, done_v[0]}, 40'd0);
         end while (done_v[0] !== 1'b1 && n < 40);
         chk("bb_period", 40'(n), 40'd17);
         chk("bb_bcd", bcd_v[0], 40'h00007);
      end
      start_v[0] = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("bb_stopped", {39'd0, busy_v[0]}, 40'd0);

      // reset in the middle of a conversion
      @(negedge clk);
      start_v[0] = 1'b1;
      bin_v[0]   = 32'd65535;
      @(posedge clk);
      #1;
      start_v[0] = 1'b0;
      repeat (8) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_busy", {39'd0, busy_v[0]}, 40'd0);
      chk("mid_rst_done", {39'd0, done_v[0]}, 40'd0);
      chk("mid_rst_bcd", bcd_v[0], 40'd0);
      chk("mid_rst_ovf_b", {39'd0, ovf_v[1]}, 40'd0);
      chk("mid_rst_neg_s", {39'd0, neg_v[2]}, 40'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      pulses = 0;
      for (int c = 0; c < 25; c++) begin
         @(posedge clk);
         #1;
         if (done_v[0] === 1'b1) pulses++;
      end
      chk("post_rst_no_done", 40'(pulses), 40'd0);
      chk("post_rst_idle", {39'd0, busy_v[0]}, 40'd0);

      run(0, 32'd1234, 40'h01234, 1'b0, 1'b0, 16, 1'b0, "a_after_rst");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/bin_to_bcd_seq.md
# bin_to_bcd_seq

Parametrised, sequential binary-to-BCD converter that uses shift-and-add-3 (double dabble), processing one input bit per clock. It accepts a start pulse, runs BIN_W shift cycles, and presents a registered packed-BCD result with a one-cycle done pulse, an overflow flag and an optional sign flag. It replaces combinational conversion in front of the seven-segment display path, where input widths above 16 bits and signed values made a single-cycle loop too slow.

## Interface
- BIN_W, 16: input binary width; at least 2.
- DIGITS, 5: number of BCD output digits; at least 1.
- SIGNED, 0: 1 = treat `bin` as two's complement and convert its magnitude; 0 = unsigned.
- clk  in  1  single clock for the whole block; all registers update on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request conversion of `bin`; sampled only when not busy.
- bin  in  BIN_W  value to convert; captured on the accepting edge and ignored afterwards.
- busy  out  1  high while a conversion is in progress.
- done  out  1  one-cycle pulse when `bcd`/`overflow`/`negative` update.
- bcd  out  4*DIGITS  packed result; digit k is at [4k+3:4k], digit 0 is the ones digit.
- overflow  out  1  result exceeded 10^DIGITS−1; `bcd` holds the value modulo 10^DIGITS.
- negative  out  1  SIGNED=1 and input was negative; constant 0 when SIGNED=0.

## Operation
- Reset values: busy=0, done=0, bcd=0, overflow=0, negative=0, state=IDLE, bit counter=0.
- The block has two states, IDLE and CONV.
- IDLE: `start`=1 → capture operand, clear working BCD register and sticky overflow, load counter with BIN_W, go to CONV.
- Operand capture:
  - SIGNED=1 and bin[BIN_W−1]=1: shift register = two's-complement negation of bin (BIN_W bits, unsigned); latch neg=1.
  - Otherwise: shift register = bin; neg=0.
  - The most negative input −2^(BIN_W−1) yields magnitude 2^(BIN_W−1) exactly.
- CONV, each edge:
  - (a) every working digit ≥5 gets +3, using 4-bit arithmetic;
  - (b) the working BCD concatenated with the shift register shifts left 1 as one vector; the shift-register MSB enters digit 0 bit 0;
  - (c) the bit shifted out of the top digit's bit 3 is ORed into sticky overflow;
  - (d) the counter decrements.
- On the edge where the counter goes 1→0:
  - `bcd` ← final working value; `overflow` ← sticky value, including this edge's carry-out; `negative` ← neg;
  - done=1; busy=0; state → IDLE.
- `done` is high for exactly one cycle and is cleared on the next edge unless a new conversion completes on it.
- `bcd`, `overflow` and `negative` hold their values until the next completion and never show intermediate working values.
- `start` while busy=1 is ignored and is not queued.
- `start` in the cycle where done=1 is accepted, because the state is already IDLE. This gives back-to-back conversions every BIN_W+1 cycles.
- Async reset asserted mid-conversion aborts it: no done pulse, and outputs return to reset values.

## Timing
- Let edge E0 be the edge that samples start=1 in IDLE.
- busy=1 from just after E0.
- Shifts occur on E1..E_BIN_W.
- done=1, busy=0 and new results appear just after E_BIN_W.
- Latency from the accepting edge to done is BIN_W cycles; throughput is one conversion per BIN_W+1 cycles.
- The add-3 stage and the shift stage together form one combinational stage per edge, DIGITS deep in parallel. Critical path: 4-bit compare + add + mux.
- The counter width is clog2(BIN_W+1).

## Test plan
- BIN_W=16, DIGITS=5, unsigned:
  - bin=16'd65535 → after 16 cycles done pulses, bcd=20'h65535, overflow=0.
  - bin=0 → bcd=0.
  - bin=16'd1234 → bcd=20'h01234.
- BIN_W=16, DIGITS=4: bin=16'd9999 → bcd=16'h9999, overflow=0. bin=16'd10000 → overflow=1, bcd=16'h0000. bin=16'd65535 → overflow=1, bcd=16'h5535.
- BIN_W=16, DIGITS=5, SIGNED=1:
  - bin=16'h8000 → bcd=20'h32768, negative=1.
  - bin=16'hFFFF → bcd=20'h00001, negative=1.
  - bin=16'd32767 → bcd=20'h32767, negative=0.
- Handshake:
  - start held high continuously with bin=7 → done pulses every 17 cycles, each a single cycle wide.
  - start pulsed mid-conversion with a different bin → ignored; the first result completes unchanged.
  - Changing bin after E0 has no effect on the result.
- Reset: assert rst_n=0 at cycle 8 of a conversion → busy, done, bcd, overflow and negative all 0 immediately. No done pulse after release. The next start converts correctly.
- BIN_W=32, DIGITS=10: bin=32'hFFFFFFFF → bcd=40'h4294967295 after 32 cycles.
